asi_reg_arb: RTL and testbench

Shares one single-port 32-bit register bank between the register-side write channel and read channel of the ASI slave path. Sits between the 128→32 lane adapter and the register file. Arbitrates write beats against read requests round-robin and keeps write bursts atomic. Sequences each access through a request/acknowledge handshake with a timeout that returns an error instead of hanging the AXI bus.

---
 rtl/asi_reg_arb.sv | 147 ++++++++++++++
 tb/tb_asi_reg_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asi_reg_arb.sv
// Round-robin arbiter sharing one single-port register bank between the ASI
// write and read channels, keeping write bursts atomic and bounding each access by a timeout.
module asi_reg_arb #(
  parameter int                REG_AW     = 20,
  parameter int                REG_DW     = 32,
  parameter int                REG_WSTRBW = REG_DW/8,
  parameter int                L          = $clog2(REG_DW/8),
  parameter int                TMO_W      = 8,
  parameter int                TMO_CYC    = 255,
  parameter logic [REG_DW-1:0] ERR_RDATA  = REG_DW'(32'hDEAD_BEEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_AW-L-1:0]   s_waddr,
  input  logic [REG_DW-1:0]     s_wdata,
  input  logic [REG_WSTRBW-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic                  s_werr,
  input  logic [REG_AW-L-1:0]   s_raddr,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [REG_DW-1:0]     s_rdata,
  output logic                  s_rerr,
  output logic                  r_req,
  output logic                  r_we,
  output logic [REG_AW-L-1:0]   r_addr,
  output logic [REG_DW-1:0]     r_wdata,
  output logic [REG_WSTRBW-1:0] r_wstrb,
  input  logic [REG_DW-1:0]     r_rdata,
  input  logic                  r_ack,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_wlock;
  logic             r_last_wr;
  logic             r_wlast;
  logic [TMO_W-1:0] r_cnt;
  logic             w_grant_w;
  logic             w_grant_r;
  logic             w_done;
  logic             w_tmo;
  logic             w_in_acc;

  assign w_in_acc = (r_state == WR) || (r_state == RD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // An open burst (wlock) starves reads; otherwise contention goes to the side not served last.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_w   = 1'b0;
    w_grant_r   = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_wlock) begin
          w_grant_w = s_wvalid;
        end else if (s_wvalid && s_rvalid) begin
          w_grant_w = !r_last_wr;
          w_grant_r = r_last_wr;
        end else begin
          w_grant_w = s_wvalid;
          w_grant_r = s_rvalid;
        end
        if (w_grant_w)      w_state_nxt = WR;
        else if (w_grant_r) w_state_nxt = RD;
      end
      WR, RD: begin
        if (r_ack) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == TMO_LIM) begin
          w_done      = 1'b1;
          w_tmo       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decision so nothing is combinational from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      busy      <= 1'b0;
      s_wready  <= 1'b0;
      s_werr    <= 1'b0;
      s_rready  <= 1'b0;
      s_rerr    <= 1'b0;
      r_wlock   <= 1'b0;
      r_last_wr <= 1'b0;
      r_wlast   <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      s_rdata   <= '0;
    end else begin
      r_req    <= (w_state_nxt == WR) || (w_state_nxt == RD);
      busy     <= (w_state_nxt != IDLE);
      s_wready <= w_done && (r_state == WR);
      s_werr   <= w_tmo  && (r_state == WR);
      s_rready <= w_done && (r_state == RD);
      s_rerr   <= w_tmo  && (r_state == RD);

      if (w_grant_w) begin
        r_we    <= 1'b1;
        r_addr  <= s_waddr;
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
        r_wlast <= s_wlast;
        r_cnt   <= '0;
      end else if (w_grant_r) begin
        r_we    <= 1'b0;
        r_addr  <= s_raddr;
        r_wstrb <= '0;
        r_cnt   <= '0;
      end else if (w_in_acc && !r_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == RD) && w_done) s_rdata <= w_tmo ? ERR_RDATA : r_rdata;

      // Lock follows the completed beat's wlast even when that beat timed out.
      if (r_state == RESP) begin
        r_last_wr <= r_we;
        if (r_we) r_wlock <= !r_wlast;
      end
    end
  end

endmodule

// File: tb/tb_asi_reg_arb.sv
// Bench for asi_reg_arb: queued upstream traffic and a register-file responder,
// checked against a transaction-level arbitration/memory model.
module tb_asi_reg_arb;

  localparam int REG_AW = 20;
  localparam int REG_DW = 32;
  localparam int REG_WSTRBW = 4;
  localparam int L = 2;
  localparam int TMO_W = 8;
  localparam int TMO_CYC = 255;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam int AW = REG_AW - L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] s_waddr = '0;
  logic [31:0]   s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_wlast = 1'b0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic          s_werr;
  logic [AW-1:0] s_raddr = '0;
  logic          s_rvalid = 1'b0;
  logic          s_rready;
  logic [31:0]   s_rdata;
  logic          s_rerr;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_rdata = '0;
  logic          r_ack = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  asi_reg_arb #(
    .REG_AW(REG_AW), .REG_DW(REG_DW), .REG_WSTRBW(REG_WSTRBW), .L(L),
    .TMO_W(TMO_W), .TMO_CYC(TMO_CYC), .ERR_RDATA(ERR_RDATA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_werr(s_werr),
    .s_raddr(s_raddr), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rerr(s_rerr),
    .r_req(r_req), .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_wstrb(r_wstrb), .r_rdata(r_rdata), .r_ack(r_ack), .busy(busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    logic          last;
  } wbeat_t;

  wbeat_t        wq[$];
  logic [AW-1:0] rq[$];
  logic [31:0]   regfile [16];
  logic [31:0]   ref_mem [16];

  int n_cmp = 0;
  int n_err = 0;

  bit pw, pr, drv_wv, drv_rv;
  bit req_prev, cur_w;
  logic [AW-1:0] cur_addr;
  int rcnt, cur_lat;
  bit pend, pend_w, pend_err;
  logic [31:0] pend_data;
  bit m_lock, m_last_w;
  int lat_mode = 1;
  int present_pct = 100;
  int cyc = 0;
  int last_done_cyc, n_done, order_bits, t_present;
  bit chk_gap, chk_lat, stray;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_r_req"}, r_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wready"}, s_wready, 0);
    chk({tag, "_rready"}, s_rready, 0);
    chk({tag, "_werr"}, s_werr, 0);
    chk({tag, "_rerr"}, s_rerr, 0);
    chk({tag, "_r_we"}, r_we, 0);
    chk({tag, "_r_addr"}, r_addr, 0);
    chk({tag, "_r_wdata"}, r_wdata, 0);
    chk({tag, "_r_wstrb"}, r_wstrb, 0);
    chk({tag, "_s_rdata"}, s_rdata, 0);
  endtask

  task automatic drive_up();
    if (!pw && wq.size() > 0 && $urandom_range(99) < present_pct) begin pw = 1; t_present = cyc; end
    if (!pr && rq.size() > 0 && $urandom_range(99) < present_pct) begin pr = 1; t_present = cyc; end
    s_wvalid = pw;
    if (pw) begin
      s_waddr = wq[0].addr; s_wdata = wq[0].data; s_wstrb = wq[0].strb; s_wlast = wq[0].last;
    end else begin
      s_waddr = AW'($urandom); s_wdata = $urandom; s_wstrb = 4'($urandom); s_wlast = 1'($urandom);
    end
    s_rvalid = pr;
    s_raddr = pr ? rq[0] : AW'($urandom);
    drv_wv = pw;
    drv_rv = pr;
  endtask

  task automatic step();
    bit had_pend;
    @(posedge clk); #1;
    cyc++;
    had_pend = pend;
    if (pend) begin
      chk("resp_req", r_req, 0);
      chk("resp_wready", s_wready, pend_w);
      chk("resp_rready", s_rready, !pend_w);
      if (pend_w) chk("resp_werr", s_werr, pend_err);
      else begin
        chk("resp_rerr", s_rerr, pend_err);
        chk("resp_rdata", s_rdata, pend_data);
      end
      if (chk_gap && n_done > 0) chk("throughput_gap", cyc - last_done_cyc, 3);
      last_done_cyc = cyc;
      order_bits = (order_bits << 1) | int'(pend_w);
      n_done++;
      if (pend_w) begin
        wbeat_t b;
        b = wq.pop_front();
        if (!pend_err)
          for (int i = 0; i < 4; i++)
            if (b.strb[i]) ref_mem[b.addr[3:0]][8*i +: 8] = b.data[8*i +: 8];
        m_lock = !b.last;
        pw = 0;
      end else begin
        void'(rq.pop_front());
        pr = 0;
      end
      m_last_w = pend_w;
      pend = 0;
    end else begin
      chk("no_ready", {s_wready, s_rready}, 0);
    end
    chk("busy", busy, r_req | had_pend);

    r_ack = 0;
    r_rdata = $urandom;
    if (r_req) begin
      if (!req_prev) begin
        bit exp_w;
        if (m_lock) exp_w = 1;
        else if (drv_wv && drv_rv) exp_w = !m_last_w;
        else exp_w = drv_wv;
        chk("grant_side", r_we, exp_w);
        if (chk_lat) chk("grant_latency", cyc - t_present, 1);
        cur_w = exp_w;
        if (exp_w && wq.size() > 0) begin
          cur_addr = wq[0].addr;
          chk("grant_waddr", r_addr, wq[0].addr);
          chk("grant_wdata", r_wdata, wq[0].data);
          chk("grant_wstrb", r_wstrb, wq[0].strb);
        end else if (!exp_w && rq.size() > 0) begin
          cur_addr = rq[0];
          chk("grant_raddr", r_addr, rq[0]);
          chk("grant_rstrb", r_wstrb, 0);
        end else begin
          chk("grant_without_request", {drv_wv, drv_rv}, {exp_w, !exp_w});
        end
        rcnt = 0;
        cur_lat = (lat_mode < 0) ? $urandom_range(1, 4) : lat_mode;
      end
      rcnt++;
      if (rcnt == TMO_CYC + 2) chk("req_overrun", rcnt, TMO_CYC + 1);
      if (rcnt == cur_lat) begin
        r_ack = 1;
        pend = 1; pend_w = cur_w; pend_err = 0;
        if (cur_w) begin
          for (int i = 0; i < 4; i++)
            if (r_wstrb[i]) regfile[r_addr[3:0]][8*i +: 8] = r_wdata[8*i +: 8];
        end else begin
          r_rdata = regfile[r_addr[3:0]];
          pend_data = ref_mem[cur_addr[3:0]];
        end
      end else if (rcnt == TMO_CYC + 1) begin
        pend = 1; pend_w = cur_w; pend_err = 1; pend_data = ERR_RDATA;
      end
    end else if (stray) begin
      r_ack = 1;
      stray = 0;
    end
    req_prev = r_req;
    drive_up();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while ((wq.size() > 0 || rq.size() > 0 || req_prev || pend) && n < max_cyc) begin
      step();
      n++;
    end
    chk("run_left_over", wq.size() + rq.size(), 0);
    step();
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin v = $urandom; regfile[i] = v; ref_mem[i] = v; end

    #3;
    chk_reset_vals("rst");

    // Contention from reset: write first, then strict alternation at one access per 3 cycles.
    for (int i = 0; i < 3; i++) begin
      wq.push_back('{addr: AW'($urandom_range(15)), data: $urandom, strb: 4'hF, last: 1'b1});
      rq.push_back(AW'($urandom_range(15)));
    end
    lat_mode = 1; present_pct = 100;
    drive_up();
    @(negedge clk); rst_n = 1;
    chk_gap = 1; order_bits = 0; n_done = 0;
    run_until_idle(200);
    chk("order_contention", order_bits & 63, 6'b101010);
    chk_gap = 0;

    // Single read, ack after 2 cycles.
    regfile[5] = 32'h1234_5678; ref_mem[5] = 32'h1234_5678;
    rq.push_back(AW'(5));
    lat_mode = 2; chk_lat = 1;
    drive_up();
    run_until_idle(50);
    chk_lat = 0;
    chk("single_rdata", s_rdata, 32'h1234_5678);

    // 4-beat burst holds off a pending read.
    order_bits = 0;
    for (int i = 0; i < 4; i++)
      wq.push_back('{addr: AW'(i), data: $urandom, strb: 4'($urandom), last: (i == 3)});
    rq.push_back(AW'(2));
    lat_mode = 1;
    drive_up();
    run_until_idle(100);
    chk("order_burst", order_bits & 31, 5'b11110);

    // Read timeout, then a normal read.
    rq.push_back(AW'(3));
    lat_mode = 0;
    drive_up();
    run_until_idle(400);
    chk("tmo_rdata", s_rdata, ERR_RDATA);
    rq.push_back(AW'(3));
    lat_mode = 2;
    drive_up();
    run_until_idle(50);
    chk("post_tmo_rdata", s_rdata, ref_mem[3]);

    // Ack exactly on the timeout cycle wins.
    rq.push_back(AW'(7));
    lat_mode = TMO_CYC + 1;
    drive_up();
    run_until_idle(400);
    chk("coincident_rdata", s_rdata, ref_mem[7]);

    // Stray ack while idle.
    v = s_rdata;
    stray = 1;
    step();
    step();
    chk("stray_rdata", s_rdata, v);
    chk("stray_req", r_req, 0);

    // Async reset during a write access.
    wq.push_back('{addr: AW'(9), data: 32'hCAFE_F00D, strb: 4'hF, last: 1'b1});
    lat_mode = 0;
    drive_up();
    repeat (3) step();
    chk("pre_rst_req", r_req, 1);
    #2 rst_n = 0;
    #1 chk_reset_vals("mid_rst");
    r_ack = 0;
    @(negedge clk); rst_n = 1;
    req_prev = 0; pend = 0; rcnt = 0; m_lock = 0; m_last_w = 0; lat_mode = 1;
    run_until_idle(50);
    chk("post_rst_mem", ref_mem[9], 32'hCAFE_F00D);

    // Randomized traffic with bursts, random presentation and ack latency.
    for (int i = 0; i < 120; i++) begin
      wq.push_back('{addr: AW'($urandom_range(15)), data: $urandom, strb: 4'($urandom),
                     last: ($urandom_range(9) < 7) || (i == 119)});
      rq.push_back(AW'($urandom_range(15)));
    end
    lat_mode = -1; present_pct = 60;
    drive_up();
    run_until_idle(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
